// File: rtl/sn74hc595_rx.sv
// Receive-side model of an SN74HC595: oversamples the three-wire link on clk and
// mirrors the chip's shift and storage registers, with a frame-length check.
module sn74hc595_rx #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             SN74HC595_data,
  input  logic             SN74HC595_data_clk,
  input  logic             SN74HC595_refresh_clk,
  output logic [WIDTH-1:0] o_buf,
  output logic             o_valid,
  output logic             o_frame_err,
  output logic [CNT_W-1:0] o_bit_cnt
);

  localparam int unsigned       PrimeW    = $clog2(SYNC_STAGES + 1);
  localparam logic [PrimeW-1:0] PrimeLast = PrimeW'(SYNC_STAGES);
  localparam logic [CNT_W-1:0]  WidthCnt  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0]  CntOne    = CNT_W'(1);

  typedef enum logic [0:0] {StPrime, StRun} state_e;

  state_e               state_q;
  logic [PrimeW-1:0]    prime_cnt_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic [SYNC_STAGES-1:0] dclk_sync_q;
  logic [SYNC_STAGES-1:0] rclk_sync_q;
  logic                 dclk_prev_q;
  logic                 rclk_prev_q;
  logic [WIDTH-1:0]     sr_q;
  logic [CNT_W-1:0]     bit_cnt_q;

  logic data_s;
  logic dclk_s;
  logic rclk_s;
  logic shift_rise;
  logic latch_rise;

  // Equal-depth synchronizers keep data aligned with its shift clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_sync_q <= '0;
      dclk_sync_q <= '0;
      rclk_sync_q <= '0;
      dclk_prev_q <= 1'b0;
      rclk_prev_q <= 1'b0;
    end else begin
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], SN74HC595_data};
      dclk_sync_q <= {dclk_sync_q[SYNC_STAGES-2:0], SN74HC595_data_clk};
      rclk_sync_q <= {rclk_sync_q[SYNC_STAGES-2:0], SN74HC595_refresh_clk};
      dclk_prev_q <= dclk_sync_q[SYNC_STAGES-1];
      rclk_prev_q <= rclk_sync_q[SYNC_STAGES-1];
    end
  end

  assign data_s = data_sync_q[SYNC_STAGES-1];
  assign dclk_s = dclk_sync_q[SYNC_STAGES-1];
  assign rclk_s = rclk_sync_q[SYNC_STAGES-1];

  // Edges are masked while priming so lines high at reset release are ignored.
  assign shift_rise = (state_q == StRun) && dclk_s && !dclk_prev_q;
  assign latch_rise = (state_q == StRun) && rclk_s && !rclk_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StPrime;
      prime_cnt_q <= '0;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      o_buf       <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_valid <= 1'b0;

      unique case (state_q)
        StPrime: begin
          if (prime_cnt_q == PrimeLast) begin
            state_q <= StRun;
          end else begin
            prime_cnt_q <= prime_cnt_q + 1'b1;
          end
        end
        StRun: ;
      endcase

      if (shift_rise) begin
        sr_q <= {sr_q[WIDTH-2:0], data_s};
      end

      // A coincident shift is counted into the new frame; the latch sees pre-shift sr.
      if (latch_rise) begin
        o_buf       <= sr_q;
        o_valid     <= 1'b1;
        o_frame_err <= (bit_cnt_q != WidthCnt);
        bit_cnt_q   <= shift_rise ? CntOne : '0;
      end else if (shift_rise && (bit_cnt_q != '1)) begin
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end
    end
  end

  assign o_bit_cnt = bit_cnt_q;

endmodule

// File: tb/tb_sn74hc595_rx.sv
// Directed bench for sn74hc595_rx: frames, short/long frames, coincident edges,
// reset behaviour and saturation, each checked against hand-computed values.
module tb_sn74hc595_rx;

  logic       clk;
  logic       rst;
  logic       sdata;
  logic       dclk;
  logic       rclk;
  logic [7:0] o_buf;
  logic       o_valid;
  logic       o_frame_err;
  logic [3:0] o_bit_cnt;

  int errors;
  int checks;

  sn74hc595_rx #(
    .WIDTH      (8),
    .SYNC_STAGES(2),
    .CNT_W      (4)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .SN74HC595_data       (sdata),
    .SN74HC595_data_clk   (dclk),
    .SN74HC595_refresh_clk(rclk),
    .o_buf                (o_buf),
    .o_valid              (o_valid),
    .o_frame_err          (o_frame_err),
    .o_bit_cnt            (o_bit_cnt)
  );

  initial clk = 1'b0;
  always #42 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1);
  end

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // 4-cycle data_clk period: 2 low with data set, 2 high.
  task automatic shift_bit(input logic b);
    sdata = b;
    dclk  = 1'b0;
    wait_cycles(2);
    dclk = 1'b1;
    wait_cycles(2);
    dclk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) shift_bit(v[i]);
  endtask

  // Pulses refresh and reports how many cycles o_valid was high and when it first rose.
  task automatic latch(output int vcnt, output int vat);
    vcnt = 0;
    vat  = 0;
    rclk = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (o_valid) begin
        vcnt++;
        if (vat == 0) vat = i;
      end
      if (i == 2) rclk = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; sdata = 1'b0; dclk = 1'b0; rclk = 1'b0;
    wait_cycles(3);
    checks++; if (o_buf !== 8'h00) begin errors++;
      $display("FAIL reset_buf: got %h expected 00", o_buf); end
    checks++; if (o_valid !== 1'b0) begin errors++;
      $display("FAIL reset_valid: got %b expected 0", o_valid); end
    checks++; if (o_frame_err !== 1'b0) begin errors++;
      $display("FAIL reset_err: got %b expected 0", o_frame_err); end
    checks++; if (o_bit_cnt !== 4'd0) begin errors++;
      $display("FAIL reset_cnt: got %0d expected 0", o_bit_cnt); end
    rst = 1'b0;
    wait_cycles(4);
  endtask

  task automatic test_basic_frame;
    int vcnt, vat;
    shift_bit(1); shift_bit(0); shift_bit(1); shift_bit(1);
    shift_bit(0); shift_bit(0); shift_bit(1); shift_bit(0);
    wait_cycles(2);
    checks++; if (o_bit_cnt !== 4'd8) begin errors++;
      $display("FAIL basic_cnt: got %0d expected 8", o_bit_cnt); end
    latch(vcnt, vat);
    checks++; if (o_buf !== 8'hB2) begin errors++;
      $display("FAIL basic_buf: got %h expected b2", o_buf); end
    checks++; if (vcnt !== 1) begin errors++;
      $display("FAIL basic_valid_len: got %0d expected 1", vcnt); end
    checks++; if (vat !== 3) begin errors++;
      $display("FAIL basic_valid_lat: got %0d expected 3", vat); end
    checks++; if (o_frame_err !== 1'b0) begin errors++;
      $display("FAIL basic_err: got %b expected 0", o_frame_err); end
    checks++; if (o_bit_cnt !== 4'd0) begin errors++;
      $display("FAIL basic_cnt_clr: got %0d expected 0", o_bit_cnt); end
  endtask

  task automatic test_short_frame;
    int vcnt, vat;
    logic [6:0] bits;
    bits = 7'b1100101;
    for (int i = 6; i >= 0; i--) shift_bit(bits[i]);
    latch(vcnt, vat);
    // sr held 8'hB2; after 7 shifts its LSB (0) reaches the MSB.
    checks++; if (o_buf !== 8'h65) begin errors++;
      $display("FAIL short_buf: got %h expected 65", o_buf); end
    checks++; if (o_frame_err !== 1'b1) begin errors++;
      $display("FAIL short_err: got %b expected 1", o_frame_err); end
    send_byte(8'h5A);
    latch(vcnt, vat);
    checks++; if (o_buf !== 8'h5A) begin errors++;
      $display("FAIL clean_buf: got %h expected 5a", o_buf); end
    checks++; if (o_frame_err !== 1'b0) begin errors++;
      $display("FAIL clean_err: got %b expected 0", o_frame_err); end
  endtask

  task automatic test_same_cycle;
    int vcnt;
    vcnt = 0;
    send_byte(8'hFF);
    sdata = 1'b0;
    wait_cycles(2);
    dclk = 1'b1;
    rclk = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (o_valid) vcnt++;
      if (i == 2) begin dclk = 1'b0; rclk = 1'b0; end
    end
    checks++; if (o_buf !== 8'hFF) begin errors++;
      $display("FAIL same_buf: got %h expected ff", o_buf); end
    checks++; if (o_bit_cnt !== 4'd1) begin errors++;
      $display("FAIL same_cnt: got %0d expected 1", o_bit_cnt); end
    checks++; if (o_frame_err !== 1'b0) begin errors++;
      $display("FAIL same_err: got %b expected 0", o_frame_err); end
    checks++; if (vcnt !== 1) begin errors++;
      $display("FAIL same_valid: got %0d expected 1", vcnt); end
  endtask

  task automatic test_prime_blank;
    int vcnt;
    vcnt = 0;
    rst = 1'b1;
    sdata = 1'b1; dclk = 1'b1; rclk = 1'b1;
    wait_cycles(3);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (o_valid) vcnt++;
    end
    dclk = 1'b0; rclk = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (o_valid) vcnt++;
    end
    checks++; if (vcnt !== 0) begin errors++;
      $display("FAIL prime_valid: got %0d pulses expected 0", vcnt); end
    checks++; if (o_bit_cnt !== 4'd0) begin errors++;
      $display("FAIL prime_cnt: got %0d expected 0", o_bit_cnt); end
    checks++; if (o_buf !== 8'h00) begin errors++;
      $display("FAIL prime_buf: got %h expected 00", o_buf); end
  endtask

  task automatic test_mid_reset;
    int vcnt, vat;
    shift_bit(1); shift_bit(1); shift_bit(1); shift_bit(1);
    wait_cycles(2);
    rst = 1'b1;
    #1;
    checks++; if ({o_buf, o_valid, o_frame_err, o_bit_cnt} !== 14'd0) begin errors++;
      $display("FAIL midrst_outs: got buf=%h v=%b e=%b cnt=%0d expected all 0",
               o_buf, o_valid, o_frame_err, o_bit_cnt); end
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(4);
    send_byte(8'hC3);
    latch(vcnt, vat);
    checks++; if (o_buf !== 8'hC3) begin errors++;
      $display("FAIL midrst_buf: got %h expected c3", o_buf); end
    checks++; if (o_frame_err !== 1'b0) begin errors++;
      $display("FAIL midrst_err: got %b expected 0", o_frame_err); end
  endtask

  task automatic test_saturate;
    int vcnt, vat;
    logic [19:0] pat;
    pat = 20'hABC96;
    for (int i = 19; i >= 5; i--) shift_bit(pat[i]);
    wait_cycles(2);
    checks++; if (o_bit_cnt !== 4'd15) begin errors++;
      $display("FAIL sat15_cnt: got %0d expected 15", o_bit_cnt); end
    for (int i = 4; i >= 0; i--) shift_bit(pat[i]);
    wait_cycles(2);
    checks++; if (o_bit_cnt !== 4'd15) begin errors++;
      $display("FAIL sat20_cnt: got %0d expected 15", o_bit_cnt); end
    latch(vcnt, vat);
    checks++; if (o_frame_err !== 1'b1) begin errors++;
      $display("FAIL sat_err: got %b expected 1", o_frame_err); end
    checks++; if (o_buf !== 8'h96) begin errors++;
      $display("FAIL sat_buf: got %h expected 96", o_buf); end
  endtask

  task automatic test_back_to_back;
    int vcnt, vat;
    latch(vcnt, vat);
    checks++; if (o_buf !== 8'h96) begin errors++;
      $display("FAIL b2b_buf: got %h expected 96", o_buf); end
    checks++; if (o_frame_err !== 1'b1) begin errors++;
      $display("FAIL b2b_err: got %b expected 1", o_frame_err); end
    checks++; if (vcnt !== 1) begin errors++;
      $display("FAIL b2b_valid: got %0d expected 1", vcnt); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic_frame();
    test_short_frame();
    test_same_cycle();
    test_prime_blank();
    test_mid_reset();
    test_saturate();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sn74hc595_rx.md
# sn74hc595_rx

Receiving end of the SN74HC595 three-wire serial link driven by the LED shift-register transmitter. Oversamples `SN74HC595_data`, `SN74HC595_data_clk` and `SN74HC595_refresh_clk` on the system clock and models the chip's shift and storage registers. Presents the latched parallel byte, a one-cycle update strobe and a frame-length check. Used as an on-board loopback monitor and as the bench scoreboard for the LED path.

## Interface
- `WIDTH`, 8: shift/storage register length in bits.
- `SYNC_STAGES`, 2: synchronizer flops per input line (≥2).
- `CNT_W`, 4: bit-counter width; the counter saturates at 2^CNT_W−1.

Ports:
- `clk` input 1: system clock (12 MHz).
- `rst` input 1: reset, asynchronous, active-high.
- `SN74HC595_data` input 1: serial data, asynchronous to `clk`.
- `SN74HC595_data_clk` input 1: shift clock; acts on its rising edge.
- `SN74HC595_refresh_clk` input 1: storage (latch) clock; acts on its rising edge.
- `o_buf` output WIDTH: storage-register contents.
- `o_valid` output 1: one-cycle pulse when `o_buf` is written.
- `o_frame_err` output 1: level; 1 when the last latched frame did not contain exactly WIDTH shifts.
- `o_bit_cnt` output CNT_W: shifts seen since the last latch, saturating.

## Operation
- All three inputs pass through SYNC_STAGES flops of equal depth, so data and clocks stay mutually aligned.
- Edge detection compares the last synchronizer stage against one extra registered copy. A rise is `cur & ~prev`.
- Shift register `sr[WIDTH-1:0]`:
  - On a data_clk rise, `sr <= {sr[WIDTH-2:0], data_sync}`.
  - The first bit shifted lands in the MSB after WIDTH shifts, matching chip Q7..Q0.
- Bit counter:
  - Increments on each data_clk rise and saturates at all-ones.
  - On a refresh rise it restarts at 0, or at 1 if a shift rise occurs in the same cycle.
- On a refresh rise:
  - `o_buf <= sr`, using the pre-shift value if a shift rise occurs in the same cycle.
  - `o_valid <= 1` for one cycle.
  - `o_frame_err <= (bit_cnt != WIDTH)`, where `bit_cnt` is the pre-update count.
- Startup blanking:
  - After reset deasserts, a prime counter suppresses all edge detection for SYNC_STAGES+1 cycles.
  - The `prev` registers are loaded from live synchronized values during this window.
  - A line already high at reset release therefore produces no edge.
- States: PRIME (blanking) → RUN. `rst` returns the block to PRIME from any state.

## Timing
- Reset values: `o_buf`=0, `o_valid`=0, `o_frame_err`=0, `o_bit_cnt`=0. `sr`, synchronizers, `prev` registers and prime counter are all 0.
- Latency from a raw data_clk rise to the `sr`/`o_bit_cnt` update: SYNC_STAGES+1 clk cycles.
- Latency from a raw refresh rise to `o_buf` update with `o_valid` high: SYNC_STAGES+1 clk cycles.
- Input requirements:
  - Each clock line must hold each level for ≥2 clk cycles.
  - `SN74HC595_data` must be stable from SYNC_STAGES+1 cycles before to 1 cycle after each data_clk rise.
  - Violations cause missed or duplicated shifts; these are not detected beyond `o_frame_err`.
- Back-to-back refresh rises with no shifts in between: `o_buf` is rewritten with the unchanged `sr`, `o_valid` pulses, and `o_frame_err`=1 (count 0 ≠ WIDTH).
- More than 2^CNT_W−1 shifts: `o_bit_cnt` holds at max, and the next latch flags an error.
- Falling edges have no effect.
- `rst` asserted mid-frame: outputs clear immediately, the partial frame is discarded, and PRIME is re-entered.

## Test plan
- Reset, then shift 8 bits 1,0,1,1,0,0,1,0 at 4-cycle data_clk period, then pulse refresh → `o_buf`=8'hB2, `o_valid` high exactly 1 cycle, 3 cycles after the raw refresh rise, `o_frame_err`=0.
- Shift 7 bits, then latch → `o_frame_err`=1 and `o_buf` equals `sr` shifted 7 times. Follow with a clean 8-bit frame of 8'h5A → `o_buf`=8'h5A, `o_frame_err`=0.
- Raise data_clk and refresh in the same clk cycle after 8 shifts of 8'hFF with `data`=0 → `o_buf`=8'hFF, `o_bit_cnt`=1 afterward, no error.
- Hold data_clk and refresh high through reset release → no shift, no `o_valid` during or after PRIME, `o_bit_cnt`=0.
- Assert `rst` after 4 of 8 shifts → all outputs 0 immediately. Then send a full 8'hC3 frame → `o_buf`=8'hC3, no error.
- Drive 20 shifts without a latch → `o_bit_cnt` saturates at 15. The next latch gives `o_frame_err`=1 and `o_buf` holding the last 8 bits sent.
